issue_stage: RTL and testbench

Operand-issue stage between instruction decode and execute. It accepts one decoded instruction at a time and drives the register bank read indices from it. It holds the instruction until a 16-entry busy scoreboard shows no RAW or WAW hazard, then issues the captured operands downstream. Writeback results are bypassed and clear scoreboard bits, so dependent instructions issue without reading stale register values.

---
 rtl/issue_stage_pkg.sv | 19 +
 rtl/issue_stage_scoreboard.sv | 42 ++++
 rtl/issue_stage.sv | 126 ++++++++++++
 tb/tb_issue_stage.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_stage_pkg.sv
// Shared cpu definitions for the operand-issue stage: register file geometry
// and the issued-operand record carried in the output slot.
package issue_stage_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;
    localparam int DATA_W    = 32;

    // Issued instruction minus its opcode payload; the payload width is a
    // per-instance parameter, so it travels alongside this record.
    typedef struct packed {
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [DATA_W-1:0]    c;
        logic [REG_IDX_W-1:0] rd;
        logic                 writes_rd;
    } issue_t;

endpackage

// File: rtl/issue_stage_scoreboard.sv
// Register busy scoreboard: writeback clears, issue sets (set wins), and a
// hazard query that treats a same-cycle writeback as already retired.
module scoreboard
    import issue_stage_pkg::*;
#(
    parameter int NUM_Q = 4
) (
    input  logic                            clk,
    input  logic                            rst_async,
    input  logic                            clr_en,
    input  logic [REG_IDX_W-1:0]            clr_idx,
    input  logic                            set_en,
    input  logic [REG_IDX_W-1:0]            set_idx,
    input  logic [NUM_Q-1:0][REG_IDX_W-1:0] q_idx,
    output logic [NUM_Q-1:0]                q_busy,
    output logic [NUM_REGS-1:0]             busy
);

    logic [NUM_REGS-1:0] busy_n;

    always_comb begin
        busy_n = busy;
        if (clr_en)
            busy_n[clr_idx] = 1'b0;
        if (set_en)
            busy_n[set_idx] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)
            busy <= '0;
        else
            busy <= busy_n;
    end

    // busy[0] is never set, so r0 needs no special case here.
    for (genvar g = 0; g < NUM_Q; g++) begin : g_query
        assign q_busy[g] = busy[q_idx[g]] && !(clr_en && clr_idx == q_idx[g]);
    end

endmodule

// File: rtl/issue_stage.sv
// Operand-issue stage: holds one decoded instruction until the scoreboard
// clears RAW/WAW hazards, then issues bank/bypassed operands downstream.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int OP_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_async,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_op,
    input  logic [REG_IDX_W-1:0] in_ra,
    input  logic [REG_IDX_W-1:0] in_rb,
    input  logic [REG_IDX_W-1:0] in_rc,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_writes_rd,
    output logic [REG_IDX_W-1:0] read_a_index,
    output logic [REG_IDX_W-1:0] read_b_index,
    output logic [REG_IDX_W-1:0] read_c_index,
    input  logic [DATA_W-1:0]    read_a,
    input  logic [DATA_W-1:0]    read_b,
    input  logic [DATA_W-1:0]    read_c,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_index,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      out_op,
    output logic [DATA_W-1:0]    out_a,
    output logic [DATA_W-1:0]    out_b,
    output logic [DATA_W-1:0]    out_c,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_writes_rd,
    output logic [NUM_REGS-1:0]  busy
);

    logic                 p_valid;
    logic [OP_W-1:0]      p_op;
    logic [REG_IDX_W-1:0] p_ra, p_rb, p_rc, p_rd;
    logic                 p_writes_rd;

    logic [OP_W-1:0]      out_op_q;
    issue_t               out_q;

    logic [3:0]                q_busy;
    logic [3:0][REG_IDX_W-1:0] q_idx;
    logic hazard, out_free, issue, accept;
    logic hit_a, hit_b, hit_c;

    assign q_idx = {p_rd, p_rc, p_rb, p_ra};

    scoreboard #(.NUM_Q(4)) u_sb (
        .clk       (clk),
        .rst_async (rst_async),
        .clr_en    (wb_en),
        .clr_idx   (wb_index),
        .set_en    (issue && p_writes_rd),
        .set_idx   (p_rd),
        .q_idx     (q_idx),
        .q_busy    (q_busy),
        .busy      (busy)
    );

    assign hazard   = q_busy[0] || q_busy[1] || q_busy[2] || (p_writes_rd && q_busy[3]);
    assign out_free = !out_valid || out_ready;
    assign issue    = p_valid && !hazard && out_free;
    assign in_ready = !p_valid || issue;
    assign accept   = in_valid && in_ready;

    assign read_a_index = p_valid ? p_ra : '0;
    assign read_b_index = p_valid ? p_rb : '0;
    assign read_c_index = p_valid ? p_rc : '0;

    // Bypass: the bank is written on this same edge, so its read is stale.
    assign hit_a = wb_en && wb_index == p_ra && p_ra != '0;
    assign hit_b = wb_en && wb_index == p_rb && p_rb != '0;
    assign hit_c = wb_en && wb_index == p_rc && p_rc != '0;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            p_valid     <= 1'b0;
            p_op        <= '0;
            p_ra        <= '0;
            p_rb        <= '0;
            p_rc        <= '0;
            p_rd        <= '0;
            p_writes_rd <= 1'b0;
            out_valid   <= 1'b0;
            out_op_q    <= '0;
            out_q       <= '0;
        end else begin
            if (accept) begin
                p_valid     <= 1'b1;
                p_op        <= in_op;
                p_ra        <= in_ra;
                p_rb        <= in_rb;
                p_rc        <= in_rc;
                p_rd        <= in_rd;
                p_writes_rd <= in_writes_rd;
            end else if (issue) begin
                p_valid <= 1'b0;
            end

            if (issue) begin
                out_valid       <= 1'b1;
                out_op_q        <= p_op;
                out_q.a         <= hit_a ? wb_data : read_a;
                out_q.b         <= hit_b ? wb_data : read_b;
                out_q.c         <= hit_c ? wb_data : read_c;
                out_q.rd        <= p_rd;
                out_q.writes_rd <= p_writes_rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_op        = out_op_q;
    assign out_a         = out_q.a;
    assign out_b         = out_q.b;
    assign out_c         = out_q.c;
    assign out_rd        = out_q.rd;
    assign out_writes_rd = out_q.writes_rd;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: register bank model, expected-issue queue popped on
// each output handshake, and per-scenario tasks with inline checks.
module tb_issue_stage;

    logic        clk = 1'b0;
    logic        rst_async = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_op = '0;
    logic [3:0]  in_ra = '0, in_rb = '0, in_rc = '0, in_rd = '0;
    logic        in_writes_rd = 1'b0;
    logic [3:0]  read_a_index, read_b_index, read_c_index;
    logic [31:0] read_a, read_b, read_c;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_index = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_op, out_a, out_b, out_c;
    logic [3:0]  out_rd;
    logic        out_writes_rd;
    logic [15:0] busy;

    typedef struct {
        logic [31:0] op, a, b, c;
        logic [3:0]  rd;
        logic        wr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] regs[16];

    issue_stage #(.OP_W(32)) dut (
        .clk(clk), .rst_async(rst_async),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_rd(in_rd),
        .in_writes_rd(in_writes_rd),
        .read_a_index(read_a_index), .read_b_index(read_b_index), .read_c_index(read_c_index),
        .read_a(read_a), .read_b(read_b), .read_c(read_c),
        .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_rd(out_rd),
        .out_writes_rd(out_writes_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    assign read_a = regs[read_a_index];
    assign read_b = regs[read_b_index];
    assign read_c = regs[read_c_index];

    always @(negedge clk) begin
        if (!rst_async && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got op=%h with no issue expected", out_op);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({out_op, out_a, out_b, out_c, out_rd, out_writes_rd} !==
                    {e.op, e.a, e.b, e.c, e.rd, e.wr}) begin
                    errors++;
                    $display("FAIL out_fields: got op=%h a=%h b=%h c=%h rd=%0d wr=%b, want op=%h a=%h b=%h c=%h rd=%0d wr=%b",
                             out_op, out_a, out_b, out_c, out_rd, out_writes_rd,
                             e.op, e.a, e.b, e.c, e.rd, e.wr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction, record its expected issue, wait for acceptance.
    task automatic send(input logic [31:0] op, input logic [3:0] ra, rb, rc, rd,
                        input logic wr, input logic [31:0] ea, eb, ec);
        logic acc;
        exp_t e;
        e.op = op; e.a = ea; e.b = eb; e.c = ec; e.rd = rd; e.wr = wr;
        exp_q.push_back(e);
        in_valid = 1'b1; in_op = op; in_ra = ra; in_rb = rb; in_rc = rc;
        in_rd = rd; in_writes_rd = wr;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: op=%h never accepted, want in_ready within 50 cycles", op);
        end
    endtask

    task automatic wb_write(input logic [3:0] idx, input logic [31:0] data);
        wb_en = 1'b1; wb_index = idx; wb_data = data;
        step();
        regs[idx] = data;
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_async = 1'b1;
        #2;
        checks++;
        if ({out_valid, in_ready, busy, read_a_index, out_a, out_op} !== {1'b0, 1'b1, 16'h0, 4'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got out_valid=%b in_ready=%b busy=%h ridx=%0d out_a=%h out_op=%h, want 0 1 0000 0 0 0",
                     out_valid, in_ready, busy, read_a_index, out_a, out_op);
        end
        @(negedge clk);
        rst_async = 1'b0;
        step();
    endtask

    task automatic test_basic();
        send(32'h11, 4'd1, 4'd2, 4'd0, 4'd3, 1'b1, 32'd5, 32'd7, 32'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || read_a_index !== 4'd1 || read_b_index !== 4'd2) begin
            errors++;
            $display("FAIL basic_pending: got out_valid=%b ridx_a=%0d ridx_b=%0d, want 0 1 2",
                     out_valid, read_a_index, read_b_index);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 16'h0008) begin
            errors++;
            $display("FAIL basic_issue: got out_valid=%b busy=%h, want 1 0008", out_valid, busy);
        end
        step();
        wb_write(4'd3, 32'h0000_0033);
        @(negedge clk);
        checks++;
        if (busy !== 16'h0000) begin
            errors++;
            $display("FAIL basic_wb_clear: got busy=%h, want 0000", busy);
        end
        step();
    endtask

    task automatic test_raw();
        send(32'h21, 4'd1, 4'd0, 4'd0, 4'd3, 1'b1, 32'd5, 32'd0, 32'd0);
        send(32'h22, 4'd3, 4'd2, 4'd0, 4'd0, 1'b0, 32'hDEAD_BEEF, 32'd7, 32'd0);
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 16'h0008) begin
            errors++;
            $display("FAIL raw_stall: got out_valid=%b in_ready=%b busy=%h, want 0 0 0008", out_valid, in_ready, busy);
        end
        step();
        wb_en = 1'b1; wb_index = 4'd3; wb_data = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_issue_on_wb: got in_ready=%b, want 1", in_ready);
        end
        step();
        regs[3] = 32'hDEAD_BEEF;
        wb_en = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 16'h0000) begin
            errors++;
            $display("FAIL raw_after_wb: got out_valid=%b busy=%h, want 1 0000", out_valid, busy);
        end
        step();
    endtask

    task automatic test_waw();
        send(32'h31, 4'd0, 4'd0, 4'd0, 4'd4, 1'b1, 32'd0, 32'd0, 32'd0);
        send(32'h32, 4'd1, 4'd0, 4'd0, 4'd4, 1'b1, 32'd5, 32'd0, 32'd0);
        step();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 16'h0010 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall: got in_ready=%b busy=%h out_valid=%b, want 0 0010 0", in_ready, busy, out_valid);
        end
        step();
        wb_en = 1'b1; wb_index = 4'd4; wb_data = 32'h44;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_issue_on_wb: got in_ready=%b, want 1", in_ready);
        end
        step();
        regs[4] = 32'h44;
        wb_en = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 16'h0010) begin
            errors++;
            $display("FAIL waw_set_wins: got out_valid=%b busy=%h, want 1 0010", out_valid, busy);
        end
        step();
        wb_write(4'd4, 32'h45);
        @(negedge clk);
        checks++;
        if (busy !== 16'h0000) begin
            errors++;
            $display("FAIL waw_final_clear: got busy=%h, want 0000", busy);
        end
        step();
    endtask

    task automatic test_r0();
        send(32'h41, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 32'd0, 32'd0, 32'd0);
        step();
        @(negedge clk);
        checks++;
        if (busy !== 16'h0000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL r0_write: got busy=%h out_valid=%b, want 0000 1", busy, out_valid);
        end
        step();
        send(32'h42, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_no_stall: got in_ready=%b, want 1", in_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL r0_reader_issue: got out_valid=%b, want 1", out_valid);
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1'b0;
        send(32'h51, 4'd1, 4'd0, 4'd0, 4'd7, 1'b0, 32'd5, 32'd0, 32'd0);
        send(32'h52, 4'd0, 4'd2, 4'd0, 4'd8, 1'b0, 32'd0, 32'd7, 32'd0);
        e.op = 32'h53; e.a = 32'd0; e.b = 32'd0; e.c = 32'd7; e.rd = 4'd9; e.wr = 1'b0;
        exp_q.push_back(e);
        in_valid = 1'b1; in_op = 32'h53; in_ra = 4'd0; in_rb = 4'd0; in_rc = 4'd2;
        in_rd = 4'd9; in_writes_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_op !== 32'h51 || out_a !== 32'd5 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got out_valid=%b op=%h a=%h in_ready=%b, want 1 51 5 0",
                         i, out_valid, out_op, out_a, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_op !== 32'h51 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release0: got op=%h in_ready=%b, want 51 1", out_op, in_ready);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_op !== 32'h52) begin
            errors++;
            $display("FAIL bp_release1: got out_valid=%b op=%h, want 1 52", out_valid, out_op);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_op !== 32'h53) begin
            errors++;
            $display("FAIL bp_release2: got out_valid=%b op=%h, want 1 53", out_valid, out_op);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid=%b, want 0", out_valid);
        end
        step();
    endtask

    task automatic test_reset_mid_stall();
        send(32'h61, 4'd0, 4'd0, 4'd0, 4'd6, 1'b1, 32'd0, 32'd0, 32'd0);
        send(32'h62, 4'd6, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0, 32'd0, 32'd0);
        step();
        @(negedge clk);
        checks++;
        if (busy !== 16'h0040 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_stall: got busy=%h in_ready=%b, want 0040 0", busy, in_ready);
        end
        step();
        #2 rst_async = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 16'h0000 || in_ready !== 1'b1 || read_a_index !== 4'd0) begin
            errors++;
            $display("FAIL rst_async_clear: got out_valid=%b busy=%h in_ready=%b ridx=%0d, want 0 0000 1 0",
                     out_valid, busy, in_ready, read_a_index);
        end
        checks++;
        if (exp_q.size() != 1) begin
            errors++;
            $display("FAIL rst_discard_queue: got %0d pending expectations, want 1", exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        rst_async = 1'b0;
        step();
        send(32'h63, 4'd6, 4'd1, 4'd0, 4'd0, 1'b0, regs[6], 32'd5, 32'd0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_new_no_stall: got in_ready=%b, want 1", in_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_new_issue: got out_valid=%b, want 1", out_valid);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++)
            regs[i] = 32'h1000_0000 + i;
        regs[0] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        #1;
        test_reset();
        test_basic();
        test_raw();
        test_waw();
        test_r0();
        test_back_to_back();
        test_reset_mid_stall();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d unissued expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
